// File: rtl/l2_line_responder.sv
// rtl/l2_line_responder.sv - AXI4 slave serving 64-byte line fills and writebacks from a line store
// Independent read/write FSMs, one outstanding burst per direction, fixed read latency.
module l2_line_responder #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 512,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam int                LINE_W   = ADDR_WIDTH - 5;
    localparam int                STRB_W   = DATA_WIDTH / 8;
    localparam logic [LINE_W-1:0] DEPTH_L  = LINE_W'(DEPTH);
    localparam logic [3:0]        LAT_LAST = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Extra top bit of the subtraction is the borrow: address below BASE_ADDR.
    logic [ADDR_WIDTH:0]   w_ar_off;
    logic [ADDR_WIDTH:0]   w_aw_off;
    logic [LINE_W-1:0]     w_ar_line;
    logic [LINE_W-1:0]     w_aw_line;
    logic                  w_unused;

    assign w_ar_off  = {1'b0, s_araddr} - {1'b0, BASE_ADDR};
    assign w_aw_off  = {1'b0, s_awaddr} - {1'b0, BASE_ADDR};
    assign w_ar_line = {1'b0, w_ar_off[ADDR_WIDTH-1:6]};
    assign w_aw_line = {1'b0, w_aw_off[ADDR_WIDTH-1:6]};
    assign w_unused  = ^{w_ar_off[5:0], w_aw_off[5:0]};

    rstate_t               r_rstate;
    rstate_t               w_rnext;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [LINE_W-1:0]     r_rline;
    logic                  r_rbelow;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rbeat;
    logic [3:0]            r_lat_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  w_rd_load;
    logic [LINE_W-1:0]     w_rd_base;
    logic                  w_rd_below;
    logic [7:0]            w_rd_beat;
    logic [LINE_W-1:0]     w_rd_line;
    logic                  w_rd_oob;

    assign w_rd_line = w_rd_base + LINE_W'(w_rd_beat);
    assign w_rd_oob  = w_rd_below || (w_rd_line >= DEPTH_L);
    assign s_rid     = r_rid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

    always_ff @(posedge clk) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext    = r_rstate;
        w_rd_load  = 1'b0;
        w_rd_base  = r_rline;
        w_rd_below = r_rbelow;
        w_rd_beat  = 8'd0;
        s_arready  = 1'b0;
        s_rvalid   = 1'b0;
        s_rlast    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) begin
                    if (RD_LAT == 0) begin
                        w_rnext    = R_DATA;
                        w_rd_load  = 1'b1;
                        w_rd_base  = w_ar_line;
                        w_rd_below = w_ar_off[ADDR_WIDTH];
                    end else begin
                        w_rnext = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_rnext   = R_DATA;
                    w_rd_load = 1'b1;
                end
            end
            R_DATA: begin
                s_rvalid = 1'b1;
                s_rlast  = (r_rbeat == r_rlen);
                if (s_rready) begin
                    if (r_rbeat == r_rlen) begin
                        w_rnext = R_IDLE;
                    end else begin
                        w_rd_load = 1'b1;
                        w_rd_beat = r_rbeat + 8'd1;
                    end
                end
            end
            default: w_rnext = R_IDLE;
        endcase
        if (rst) begin
            s_arready = 1'b0;
            s_rvalid  = 1'b0;
            s_rlast   = 1'b0;
        end
    end

    // Memory read happens at the same edge as any write commit, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rid     <= '0;
            r_rline   <= '0;
            r_rbelow  <= 1'b0;
            r_rlen    <= 8'd0;
            r_rbeat   <= 8'd0;
            r_lat_cnt <= 4'd0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            if (r_rstate == R_IDLE && s_arvalid) begin
                r_rid     <= s_arid;
                r_rline   <= w_ar_line;
                r_rbelow  <= w_ar_off[ADDR_WIDTH];
                r_rlen    <= s_arlen;
                r_rbeat   <= 8'd0;
                r_lat_cnt <= 4'd0;
            end
            if (r_rstate == R_WAIT) r_lat_cnt <= r_lat_cnt + 4'd1;
            if (w_rd_load) begin
                r_rbeat <= w_rd_beat;
                r_rdata <= w_rd_oob ? '0 : r_mem[w_rd_line[IDX_W-1:0]];
                r_rresp <= w_rd_oob ? 2'b10 : 2'b00;
            end
        end
    end

    wstate_t               r_wstate;
    wstate_t               w_wnext;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [LINE_W-1:0]     r_wline;
    logic                  r_wbelow;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wbeat;
    logic                  r_werr;
    logic                  w_wr_fire;
    logic [LINE_W-1:0]     w_wr_line;
    logic                  w_wr_oob;

    assign w_wr_line = r_wline + LINE_W'(r_wbeat);
    assign w_wr_oob  = r_wbelow || (w_wr_line >= DEPTH_L);
    assign s_bid     = r_bid;

    always_ff @(posedge clk) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wnext;
    end

    always_comb begin
        w_wnext   = r_wstate;
        w_wr_fire = 1'b0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = 2'b00;
        case (r_wstate)
            W_IDLE: begin
                s_awready = 1'b1;
                if (s_awvalid) w_wnext = W_DATA;
            end
            W_DATA: begin
                s_wready = 1'b1;
                if (s_wvalid) begin
                    w_wr_fire = 1'b1;
                    if (r_wbeat == r_wlen) w_wnext = W_RESP;
                end
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = r_werr ? 2'b10 : 2'b00;
                if (s_bready) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
        if (rst) begin
            w_wr_fire = 1'b0;
            s_awready = 1'b0;
            s_wready  = 1'b0;
            s_bvalid  = 1'b0;
            s_bresp   = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bid    <= '0;
            r_wline  <= '0;
            r_wbelow <= 1'b0;
            r_wlen   <= 8'd0;
            r_wbeat  <= 8'd0;
            r_werr   <= 1'b0;
        end else begin
            if (r_wstate == W_IDLE && s_awvalid) begin
                r_bid    <= s_awid;
                r_wline  <= w_aw_line;
                r_wbelow <= w_aw_off[ADDR_WIDTH];
                r_wlen   <= s_awlen;
                r_wbeat  <= 8'd0;
                r_werr   <= 1'b0;
            end
            if (w_wr_fire) begin
                r_wbeat <= r_wbeat + 8'd1;
                if (w_wr_oob || (s_wlast != (r_wbeat == r_wlen))) r_werr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire && !w_wr_oob) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_wstrb[b]) r_mem[w_wr_line[IDX_W-1:0]][b*8 +: 8] <= s_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_l2_line_responder.sv
// tb/tb_l2_line_responder.sv - directed self-checking bench for l2_line_responder
module tb_l2_line_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   s_awid = '0;
    logic [63:0]  s_awaddr = '0;
    logic [7:0]   s_awlen = '0;
    logic         s_awvalid = 1'b0;
    logic         s_awready;
    logic [511:0] s_wdata = '0;
    logic [63:0]  s_wstrb = '0;
    logic         s_wlast = 1'b0;
    logic         s_wvalid = 1'b0;
    logic         s_wready;
    logic [3:0]   s_bid;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready = 1'b0;
    logic [3:0]   s_arid = '0;
    logic [63:0]  s_araddr = '0;
    logic [7:0]   s_arlen = '0;
    logic         s_arvalid = 1'b0;
    logic         s_arready;
    logic [3:0]   s_rid;
    logic [511:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic         s_rvalid;
    logic         s_rready = 1'b0;

    always #5 clk = ~clk;

    l2_line_responder dut (
        .clk(clk), .rst(rst),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [511:0] wd [16];
    logic [63:0]  ws [16];
    logic         wl [16];
    logic [511:0] rdd [16];
    logic [1:0]   rrs [16];
    logic         rls [16];
    logic [3:0]   rids [16];

    logic [1:0] g_bresp;
    logic [3:0] g_bid;
    logic       g_bnext;
    logic       g_to;
    int         g_lat;
    int         g_stable_bad;
    logic       g_ar_bad;

    task automatic wr_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            output logic [1:0] bresp, output logic [3:0] bid, output logic b_next, output logic to);
        int n;
        to = 1'b0; bresp = '0; bid = '0; b_next = 1'b0;
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_awready && n < 50) begin @(negedge clk); n++; end
        if (!s_awready) to = 1'b1;
        @(posedge clk); #1 s_awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            s_wvalid = 1'b1; s_wdata = wd[k]; s_wstrb = ws[k]; s_wlast = wl[k];
            n = 0;
            @(negedge clk);
            while (!s_wready && n < 50) begin @(negedge clk); n++; end
            if (!s_wready) to = 1'b1;
            @(posedge clk); #1;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        @(negedge clk);
        b_next = s_bvalid;
        n = 0;
        while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_bvalid) to = 1'b1;
        bresp = s_bresp; bid = s_bid;
        s_bready = 1'b1;
        @(posedge clk); #1 s_bready = 1'b0;
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len, input logic toggle,
                            output int lat, output logic to, output int stable_bad, output logic ar_bad);
        int n, k, cyc;
        logic prev_stall, prev_l;
        logic [511:0] prev_d;
        logic [1:0] prev_r;
        to = 1'b0; stable_bad = 0; ar_bad = 1'b0; lat = 0;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        if (!s_arready) to = 1'b1;
        @(posedge clk); #1 s_arvalid = 1'b0;
        k = 0; cyc = 0; prev_stall = 1'b0; prev_l = 1'b0; prev_d = '0; prev_r = '0;
        while (k <= int'(len) && cyc < 200) begin
            s_rready = toggle ? ((cyc % 2) == 1) : 1'b1;
            @(negedge clk);
            cyc++;
            if (lat == 0 && s_rvalid) lat = cyc;
            if (s_arready) ar_bad = 1'b1;
            if (prev_stall && (!s_rvalid || s_rdata !== prev_d || s_rlast !== prev_l || s_rresp !== prev_r))
                stable_bad++;
            prev_stall = s_rvalid && !s_rready;
            prev_d = s_rdata; prev_l = s_rlast; prev_r = s_rresp;
            if (s_rvalid && s_rready) begin
                rdd[k] = s_rdata; rrs[k] = s_rresp; rls[k] = s_rlast; rids[k] = s_rid;
                k++;
            end
            @(posedge clk); #1;
        end
        s_rready = 1'b0;
        if (k <= int'(len)) to = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (s_awready !== 1'b0) $display("FAIL reset_awready got %0b want 0", s_awready); else n_pass++;
        n_total++; if (s_wready !== 1'b0) $display("FAIL reset_wready got %0b want 0", s_wready); else n_pass++;
        n_total++; if (s_bvalid !== 1'b0) $display("FAIL reset_bvalid got %0b want 0", s_bvalid); else n_pass++;
        n_total++; if (s_bresp !== 2'b00) $display("FAIL reset_bresp got %0b want 0", s_bresp); else n_pass++;
        n_total++; if (s_bid !== 4'd0) $display("FAIL reset_bid got %0d want 0", s_bid); else n_pass++;
        n_total++; if (s_arready !== 1'b0) $display("FAIL reset_arready got %0b want 0", s_arready); else n_pass++;
        n_total++; if (s_rvalid !== 1'b0) $display("FAIL reset_rvalid got %0b want 0", s_rvalid); else n_pass++;
        n_total++; if (s_rlast !== 1'b0) $display("FAIL reset_rlast got %0b want 0", s_rlast); else n_pass++;
        n_total++; if (s_rresp !== 2'b00) $display("FAIL reset_rresp got %0b want 0", s_rresp); else n_pass++;
        n_total++; if (s_rid !== 4'd0) $display("FAIL reset_rid got %0d want 0", s_rid); else n_pass++;
        n_total++; if (s_rdata !== 512'd0) $display("FAIL reset_rdata got %h want 0", s_rdata); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_total++; if (s_arready !== 1'b1) $display("FAIL post_reset_arready got %0b want 1", s_arready); else n_pass++;
        n_total++; if (s_awready !== 1'b1) $display("FAIL post_reset_awready got %0b want 1", s_awready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [511:0] exp;
        exp = {8{64'hDEADBEEF12345678}};
        wd[0] = exp; ws[0] = '1; wl[0] = 1'b1;
        wr_burst(4'd5, 64'h2000, 8'd0, g_bresp, g_bid, g_bnext, g_to);
        n_total++; if (g_to !== 1'b0) $display("FAIL single_wr_timeout got %0b want 0", g_to); else n_pass++;
        n_total++; if (g_bnext !== 1'b1) $display("FAIL single_bvalid_next got %0b want 1", g_bnext); else n_pass++;
        n_total++; if (g_bresp !== 2'b00) $display("FAIL single_bresp got %0b want 00", g_bresp); else n_pass++;
        n_total++; if (g_bid !== 4'd5) $display("FAIL single_bid got %0d want 5", g_bid); else n_pass++;
        @(negedge clk);
        n_total++; if (s_awready !== 1'b1) $display("FAIL single_awready_after_b got %0b want 1", s_awready); else n_pass++;
        @(posedge clk); #1;
        rd_burst(4'd9, 64'h2000, 8'd0, 1'b0, g_lat, g_to, g_stable_bad, g_ar_bad);
        n_total++; if (g_to !== 1'b0) $display("FAIL single_rd_timeout got %0b want 0", g_to); else n_pass++;
        n_total++; if (g_lat !== 3) $display("FAIL single_rd_latency got %0d want 3", g_lat); else n_pass++;
        n_total++; if (rdd[0] !== exp) $display("FAIL single_rdata got %h want %h", rdd[0], exp); else n_pass++;
        n_total++; if (rls[0] !== 1'b1) $display("FAIL single_rlast got %0b want 1", rls[0]); else n_pass++;
        n_total++; if (rrs[0] !== 2'b00) $display("FAIL single_rresp got %0b want 00", rrs[0]); else n_pass++;
        n_total++; if (rids[0] !== 4'd9) $display("FAIL single_rid got %0d want 9", rids[0]); else n_pass++;
        @(negedge clk);
        n_total++; if (s_arready !== 1'b1) $display("FAIL single_arready_after_r got %0b want 1", s_arready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_partial_strobes();
        logic [511:0] exp;
        exp = {{256{1'b0}}, {256{1'b1}}};
        wd[0] = '0; ws[0] = '1; wl[0] = 1'b1;
        wr_burst(4'd1, 64'h9000, 8'd0, g_bresp, g_bid, g_bnext, g_to);
        wd[0] = '1; ws[0] = 64'h0000_0000_FFFF_FFFF;
        wr_burst(4'd1, 64'h9000, 8'd0, g_bresp, g_bid, g_bnext, g_to);
        n_total++; if (g_bresp !== 2'b00) $display("FAIL partial_bresp got %0b want 00", g_bresp); else n_pass++;
        wd[0] = '0; ws[0] = 64'hFFFF_FFFF_0000_0000;
        wr_burst(4'd1, 64'h9000, 8'd0, g_bresp, g_bid, g_bnext, g_to);
        rd_burst(4'd2, 64'h9000, 8'd0, 1'b0, g_lat, g_to, g_stable_bad, g_ar_bad);
        n_total++; if (g_to !== 1'b0) $display("FAIL partial_rd_timeout got %0b want 0", g_to); else n_pass++;
        n_total++; if (rdd[0] !== exp) $display("FAIL partial_rdata got %h want %h", rdd[0], exp); else n_pass++;
    endtask

    task automatic test_burst();
        logic [63:0] w;
        logic [511:0] exp;
        for (int k = 0; k < 4; k++) begin
            w = 64'hA5A5_0000_0000_0000 + 64'(k);
            wd[k] = {8{w}}; ws[k] = '1; wl[k] = (k == 3);
        end
        wr_burst(4'd7, 64'h4000, 8'd3, g_bresp, g_bid, g_bnext, g_to);
        n_total++; if (g_to !== 1'b0 || g_bresp !== 2'b00) $display("FAIL burst_wr got to=%0b bresp=%0b want to=0 bresp=00", g_to, g_bresp); else n_pass++;
        rd_burst(4'd6, 64'h4000, 8'd3, 1'b1, g_lat, g_to, g_stable_bad, g_ar_bad);
        n_total++; if (g_to !== 1'b0) $display("FAIL burst_rd_timeout got %0b want 0", g_to); else n_pass++;
        n_total++; if (g_stable_bad !== 0) $display("FAIL burst_stall_stable got %0d changes want 0", g_stable_bad); else n_pass++;
        n_total++; if (g_ar_bad !== 1'b0) $display("FAIL burst_arready_busy got %0b want 0", g_ar_bad); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            w = 64'hA5A5_0000_0000_0000 + 64'(k);
            exp = {8{w}};
            n_total++; if (rdd[k] !== exp) $display("FAIL burst_rdata%0d got %h want %h", k, rdd[k], exp); else n_pass++;
            n_total++; if (rls[k] !== (k == 3)) $display("FAIL burst_rlast%0d got %0b want %0b", k, rls[k], (k == 3)); else n_pass++;
            n_total++; if (rrs[k] !== 2'b00) $display("FAIL burst_rresp%0d got %0b want 00", k, rrs[k]); else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        logic [511:0] z, x0;
        z = {8{64'h0123_4567_89AB_CDEF}};
        x0 = {8{64'h1111_1111_1111_1111}};
        wd[0] = z; ws[0] = '1; wl[0] = 1'b1;
        wr_burst(4'd2, 64'h0, 8'd0, g_bresp, g_bid, g_bnext, g_to);
        wd[0] = x0; ws[0] = '1; wl[0] = 1'b0;
        wd[1] = {8{64'h2222_2222_2222_2222}}; ws[1] = '1; wl[1] = 1'b1;
        wr_burst(4'd3, 64'hFFC0, 8'd1, g_bresp, g_bid, g_bnext, g_to);
        n_total++; if (g_to !== 1'b0) $display("FAIL oob_wr_timeout got %0b want 0", g_to); else n_pass++;
        n_total++; if (g_bresp !== 2'b10) $display("FAIL oob_bresp got %0b want 10", g_bresp); else n_pass++;
        rd_burst(4'd4, 64'hFFC0, 8'd1, 1'b0, g_lat, g_to, g_stable_bad, g_ar_bad);
        n_total++; if (g_to !== 1'b0) $display("FAIL oob_rd_timeout got %0b want 0", g_to); else n_pass++;
        n_total++; if (rdd[0] !== x0) $display("FAIL oob_beat0_rdata got %h want %h", rdd[0], x0); else n_pass++;
        n_total++; if (rrs[0] !== 2'b00) $display("FAIL oob_beat0_rresp got %0b want 00", rrs[0]); else n_pass++;
        n_total++; if (rdd[1] !== 512'd0) $display("FAIL oob_beat1_rdata got %h want 0", rdd[1]); else n_pass++;
        n_total++; if (rrs[1] !== 2'b10) $display("FAIL oob_beat1_rresp got %0b want 10", rrs[1]); else n_pass++;
        n_total++; if (rls[1] !== 1'b1) $display("FAIL oob_beat1_rlast got %0b want 1", rls[1]); else n_pass++;
        rd_burst(4'd4, 64'h0, 8'd0, 1'b0, g_lat, g_to, g_stable_bad, g_ar_bad);
        n_total++; if (rdd[0] !== z) $display("FAIL oob_line0_untouched got %h want %h", rdd[0], z); else n_pass++;
    endtask

    task automatic test_wlast_error();
        logic [511:0] e0, e1;
        e0 = {8{64'h5555_5555_5555_5555}};
        e1 = {8{64'h6666_6666_6666_6666}};
        wd[0] = e0; ws[0] = '1; wl[0] = 1'b1;
        wd[1] = e1; ws[1] = '1; wl[1] = 1'b1;
        wr_burst(4'd8, 64'h5000, 8'd1, g_bresp, g_bid, g_bnext, g_to);
        n_total++; if (g_to !== 1'b0) $display("FAIL wlast_wr_timeout got %0b want 0", g_to); else n_pass++;
        n_total++; if (g_bresp !== 2'b10) $display("FAIL wlast_bresp got %0b want 10", g_bresp); else n_pass++;
        rd_burst(4'd8, 64'h5000, 8'd1, 1'b0, g_lat, g_to, g_stable_bad, g_ar_bad);
        n_total++; if (rdd[0] !== e0) $display("FAIL wlast_beat0_data got %h want %h", rdd[0], e0); else n_pass++;
        n_total++; if (rdd[1] !== e1) $display("FAIL wlast_beat1_data got %h want %h", rdd[1], e1); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [511:0] old_d, new_d;
        old_d = {8{64'h0A0A_0A0A_0A0A_0A0A}};
        new_d = {8{64'hB0B0_B0B0_B0B0_B0B0}};
        wd[0] = old_d; ws[0] = '1; wl[0] = 1'b1;
        wr_burst(4'd1, 64'h3000, 8'd0, g_bresp, g_bid, g_bnext, g_to);
        s_arid = 4'd3; s_araddr = 64'h3000; s_arlen = 8'd0; s_arvalid = 1'b1;
        @(posedge clk); #1 s_arvalid = 1'b0;
        s_awid = 4'd4; s_awaddr = 64'h3000; s_awlen = 8'd0; s_awvalid = 1'b1;
        @(posedge clk); #1 s_awvalid = 1'b0;
        s_wdata = new_d; s_wstrb = '1; s_wlast = 1'b1; s_wvalid = 1'b1;
        @(posedge clk); #1 s_wvalid = 1'b0; s_wlast = 1'b0;
        @(negedge clk);
        n_total++; if (s_rvalid !== 1'b1) $display("FAIL simul_rvalid got %0b want 1", s_rvalid); else n_pass++;
        n_total++; if (s_rdata !== old_d) $display("FAIL simul_read_old got %h want %h", s_rdata, old_d); else n_pass++;
        n_total++; if (s_bvalid !== 1'b1) $display("FAIL simul_bvalid got %0b want 1", s_bvalid); else n_pass++;
        n_total++; if (s_bid !== 4'd4 || s_bresp !== 2'b00) $display("FAIL simul_bresp got bid=%0d bresp=%0b want bid=4 bresp=00", s_bid, s_bresp); else n_pass++;
        s_rready = 1'b1; s_bready = 1'b1;
        @(posedge clk); #1 s_rready = 1'b0; s_bready = 1'b0;
        rd_burst(4'd3, 64'h3000, 8'd0, 1'b0, g_lat, g_to, g_stable_bad, g_ar_bad);
        n_total++; if (g_to !== 1'b0) $display("FAIL simul_rd2_timeout got %0b want 0", g_to); else n_pass++;
        n_total++; if (rdd[0] !== new_d) $display("FAIL simul_read_new got %h want %h", rdd[0], new_d); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int n;
        logic [511:0] exp;
        exp = {8{64'hDEADBEEF12345678}};
        s_arid = 4'd11; s_araddr = 64'h4000; s_arlen = 8'd3; s_arvalid = 1'b1;
        @(posedge clk); #1 s_arvalid = 1'b0; s_rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_rvalid && n < 50) begin @(negedge clk); n++; end
        n_total++; if (s_rvalid !== 1'b1) $display("FAIL rstmid_first_beat got %0b want 1", s_rvalid); else n_pass++;
        @(posedge clk); #1 s_rready = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (s_rvalid !== 1'b0) $display("FAIL rstmid_rvalid got %0b want 0", s_rvalid); else n_pass++;
        n_total++; if (s_rdata !== 512'd0) $display("FAIL rstmid_rdata got %h want 0", s_rdata); else n_pass++;
        n_total++; if (s_rid !== 4'd0) $display("FAIL rstmid_rid got %0d want 0", s_rid); else n_pass++;
        n_total++; if (s_arready !== 1'b0) $display("FAIL rstmid_arready_in_rst got %0b want 0", s_arready); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_total++; if (s_arready !== 1'b1) $display("FAIL rstmid_arready_after got %0b want 1", s_arready); else n_pass++;
        @(posedge clk); #1;
        rd_burst(4'd1, 64'h2000, 8'd0, 1'b0, g_lat, g_to, g_stable_bad, g_ar_bad);
        n_total++; if (rdd[0] !== exp) $display("FAIL rstmid_store_kept got %h want %h", rdd[0], exp); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_partial_strobes();
        test_burst();
        test_out_of_range();
        test_wlast_error();
        test_simultaneous();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
